// File: rtl/merge_sort_ctrl_if.sv
// merge_sort_ctrl_if
//   Host-side bus of merge_sort_ctrl.
//   slave  modport : sorter side
//     in : start, descend, wr_en, wr_addr, data_in, rd_en, rd_addr
//     out: data_out, busy, done, dup, res_bank
//   master modport : host side (directions mirrored)
//   Entries are laid out as {key[INT_WIDTH], index[INDEX_WIDTH]}.
interface merge_sort_ctrl_if #(
    parameter int INT_WIDTH   = 32,
    parameter int INDEX_WIDTH = 13,
    parameter int LIST_LEN    = 8192,
    parameter int ADDR_W      = $clog2(LIST_LEN)
);
    logic                             start;
    logic                             descend;
    logic                             wr_en;
    logic [ADDR_W-1:0]                wr_addr;
    logic [INT_WIDTH+INDEX_WIDTH-1:0] data_in;
    logic                             rd_en;
    logic [ADDR_W-1:0]                rd_addr;
    logic [INT_WIDTH+INDEX_WIDTH-1:0] data_out;
    logic                             busy;
    logic                             done;
    logic                             dup;
    logic                             res_bank;

    modport slave (
        input  start, descend, wr_en, wr_addr, data_in, rd_en, rd_addr,
        output data_out, busy, done, dup, res_bank
    );

    modport master (
        output start, descend, wr_en, wr_addr, data_in, rd_en, rd_addr,
        input  data_out, busy, done, dup, res_bank
    );
endinterface

// File: rtl/merge_sort_ctrl.sv
// merge_sort_ctrl
//   Bottom-up stable merge sort of LIST_LEN {key, index} entries, ping-ponging
//   between two internal RAM banks (A, B). Supports any LIST_LEN >= 2, a
//   run-time ascending/descending order and duplicate-key detection on the
//   final pass.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : synchronous active-low reset (RAM contents are kept)
//     bus   : merge_sort_ctrl_if.slave
//       start/descend    : begin a sort (IDLE only), order latched on start
//       wr_en/wr_addr/data_in : host write into bank A while idle
//       rd_en/rd_addr/data_out: host read of result bank, 1-cycle latency
//       busy/done        : sort in progress / one-cycle completion pulse
//       dup              : sorted output contains equal keys
//       res_bank         : bank holding the result (0 = A, 1 = B)
module merge_sort_ctrl #(
    parameter int INT_WIDTH   = 32,
    parameter int INDEX_WIDTH = 13,
    parameter int LIST_LEN    = 8192,
    parameter int ADDR_W      = $clog2(LIST_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    merge_sort_ctrl_if.slave bus
);
    localparam int DW = INT_WIDTH + INDEX_WIDTH;
    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(LIST_LEN);
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    // RUN is split into read / write / turnaround sub-states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_TURN,
        S_FIN
    } state_t;

    state_t                 r_state;
    logic [ADDR_W:0]        r_w;
    logic [ADDR_W:0]        r_base;
    logic [ADDR_W:0]        r_i;
    logic [ADDR_W:0]        r_j;
    logic [ADDR_W:0]        r_k;
    logic                   r_src;
    logic                   r_desc;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_dup;
    logic                   r_res_bank;
    logic [DW-1:0]          r_data_out;
    logic [INT_WIDTH-1:0]   r_prev_key;

    logic [DW-1:0]          r_bank_a [LIST_LEN];
    logic [DW-1:0]          r_bank_b [LIST_LEN];
    logic [DW-1:0]          r_qa_a;
    logic [DW-1:0]          r_qb_a;
    logic [DW-1:0]          r_qa_b;
    logic [DW-1:0]          r_qb_b;

    logic [ADDR_W:0]        w_l_end;
    logic [ADDR_W:0]        w_r_end;
    logic [ADDR_W:0]        w_w2;
    logic [ADDR_W:0]        w_k_next;
    logic                   w_last_pass;
    logic [DW-1:0]          w_head_l;
    logic [DW-1:0]          w_head_r;
    logic [INT_WIDTH-1:0]   w_key_l;
    logic [INT_WIDTH-1:0]   w_key_r;
    logic                   w_l_valid;
    logic                   w_r_valid;
    logic                   w_take_l;
    logic [DW-1:0]          w_out;
    logic [INT_WIDTH-1:0]   w_out_key;
    logic                   w_host_we;
    logic                   w_sort_we;
    logic                   w_we_a;
    logic [ADDR_W-1:0]      w_waddr_a;
    logic [DW-1:0]          w_wdata_a;
    logic                   w_we_b;
    logic [ADDR_W-1:0]      w_ra;
    logic [ADDR_W-1:0]      w_rb;

    function automatic logic [ADDR_W:0] f_min(input logic [ADDR_W:0] a, input logic [ADDR_W:0] b);
        return (a < b) ? a : b;
    endfunction

    always_comb begin
        w_w2        = r_w << 1;
        w_l_end     = f_min(r_base + r_w, LEN);
        w_r_end     = f_min(r_base + w_w2, LEN);
        w_k_next    = r_k + ONE;
        // Only one merge spans the whole list once 2w covers it.
        w_last_pass = (w_w2 >= LEN);

        w_head_l    = r_src ? r_qa_b : r_qa_a;
        w_head_r    = r_src ? r_qb_b : r_qb_a;
        w_key_l     = w_head_l[DW-1 -: INT_WIDTH];
        w_key_r     = w_head_r[DW-1 -: INT_WIDTH];
        w_l_valid   = (r_i < w_l_end);
        w_r_valid   = (r_j < w_r_end);
        // Ties take the left head in both orders, keeping the sort stable.
        w_take_l    = w_l_valid &&
                      (!w_r_valid || (r_desc ? (w_key_l >= w_key_r) : (w_key_l <= w_key_r)));
        w_out       = w_take_l ? w_head_l : w_head_r;
        w_out_key   = w_out[DW-1 -: INT_WIDTH];

        w_host_we   = (r_state == S_IDLE) && bus.wr_en;
        w_sort_we   = (r_state == S_WR);
        w_we_a      = w_host_we || (w_sort_we && r_src);
        w_waddr_a   = w_host_we ? bus.wr_addr : r_k[ADDR_W-1:0];
        w_wdata_a   = w_host_we ? bus.data_in : w_out;
        w_we_b      = w_sort_we && !r_src;

        // An exhausted head points one past the list; keep the RAM address in range.
        w_ra        = (r_i < LEN) ? r_i[ADDR_W-1:0] : '0;
        w_rb        = (r_j < LEN) ? r_j[ADDR_W-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (w_we_a) begin
            r_bank_a[w_waddr_a] <= w_wdata_a;
        end
        if (w_we_b) begin
            r_bank_b[r_k[ADDR_W-1:0]] <= w_out;
        end
        r_qa_a <= r_bank_a[w_ra];
        r_qb_a <= r_bank_a[w_rb];
        r_qa_b <= r_bank_b[w_ra];
        r_qb_b <= r_bank_b[w_rb];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_base     <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_src      <= 1'b0;
            r_desc     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dup      <= 1'b0;
            r_res_bank <= 1'b0;
            r_data_out <= '0;
            r_prev_key <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rd_en) begin
                        r_data_out <= r_res_bank ? r_bank_b[bus.rd_addr] : r_bank_a[bus.rd_addr];
                    end
                    if (bus.start) begin
                        r_state <= S_RD;
                        r_busy  <= 1'b1;
                        r_desc  <= bus.descend;
                        r_dup   <= 1'b0;
                        r_src   <= 1'b0;
                        r_w     <= ONE;
                        r_base  <= '0;
                        r_i     <= '0;
                        r_j     <= ONE;
                        r_k     <= '0;
                    end
                end
                S_RD: begin
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_k        <= w_k_next;
                    r_prev_key <= w_out_key;
                    if (w_last_pass && (r_k != '0) && (w_out_key == r_prev_key)) begin
                        r_dup <= 1'b1;
                    end
                    if (w_k_next == w_r_end && w_r_end == LEN) begin
                        r_state <= S_TURN;
                    end else if (w_k_next == w_r_end) begin
                        // Current run pair finished: set up the next pair.
                        r_base  <= w_r_end;
                        r_i     <= w_r_end;
                        r_j     <= f_min(w_r_end + r_w, LEN);
                        r_state <= S_RD;
                    end else begin
                        if (w_take_l) begin
                            r_i <= r_i + ONE;
                        end else begin
                            r_j <= r_j + ONE;
                        end
                        r_state <= S_RD;
                    end
                end
                S_TURN: begin
                    r_src <= ~r_src;
                    r_w   <= w_w2;
                    if (w_w2 >= LEN) begin
                        r_state <= S_FIN;
                    end else begin
                        r_base  <= '0;
                        r_i     <= '0;
                        r_j     <= f_min(w_w2, LEN);
                        r_k     <= '0;
                        r_state <= S_RD;
                    end
                end
                S_FIN: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_res_bank <= r_src;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.dup      = r_dup;
    assign bus.res_bank = r_res_bank;
endmodule

// File: tb/tb_merge_sort_ctrl.sv
// tb_merge_sort_ctrl
//   Scoreboard bench for merge_sort_ctrl. Three instances (LIST_LEN 8, 5, 4)
//   share one set of host stimulus signals, steered by sel. Expected sorted
//   entries come from a stable insertion sort in the bench and are queued
//   when the data is loaded, then popped as the result bank is read back.
module tb_merge_sort_ctrl;
    localparam int IW = 8;
    localparam int XW = 4;
    localparam int DW = IW + XW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]    sel;
    logic          tb_start;
    logic          tb_desc;
    logic          tb_wr_en;
    logic          tb_rd_en;
    logic [2:0]    tb_wr_addr;
    logic [2:0]    tb_rd_addr;
    logic [DW-1:0] tb_data_in;

    logic          o_busy;
    logic          o_done;
    logic          o_dup;
    logic          o_res;
    logic [DW-1:0] o_dout;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q [$];

    merge_sort_ctrl_if #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(8)) bus8 ();
    merge_sort_ctrl_if #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(5)) bus5 ();
    merge_sort_ctrl_if #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(4)) bus4 ();

    merge_sort_ctrl #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8));
    merge_sort_ctrl #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5));
    merge_sort_ctrl #(.INT_WIDTH(IW), .INDEX_WIDTH(XW), .LIST_LEN(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));

    assign bus8.start   = tb_start && (sel == 2'd0);
    assign bus8.descend = tb_desc;
    assign bus8.wr_en   = tb_wr_en && (sel == 2'd0);
    assign bus8.wr_addr = tb_wr_addr;
    assign bus8.data_in = tb_data_in;
    assign bus8.rd_en   = tb_rd_en && (sel == 2'd0);
    assign bus8.rd_addr = tb_rd_addr;

    assign bus5.start   = tb_start && (sel == 2'd1);
    assign bus5.descend = tb_desc;
    assign bus5.wr_en   = tb_wr_en && (sel == 2'd1);
    assign bus5.wr_addr = tb_wr_addr;
    assign bus5.data_in = tb_data_in;
    assign bus5.rd_en   = tb_rd_en && (sel == 2'd1);
    assign bus5.rd_addr = tb_rd_addr;

    assign bus4.start   = tb_start && (sel == 2'd2);
    assign bus4.descend = tb_desc;
    assign bus4.wr_en   = tb_wr_en && (sel == 2'd2);
    assign bus4.wr_addr = tb_wr_addr[1:0];
    assign bus4.data_in = tb_data_in;
    assign bus4.rd_en   = tb_rd_en && (sel == 2'd2);
    assign bus4.rd_addr = tb_rd_addr[1:0];

    always_comb begin
        o_busy = bus8.busy;
        o_done = bus8.done;
        o_dup  = bus8.dup;
        o_res  = bus8.res_bank;
        o_dout = bus8.data_out;
        if (sel == 2'd1) begin
            o_busy = bus5.busy;
            o_done = bus5.done;
            o_dup  = bus5.dup;
            o_res  = bus5.res_bank;
            o_dout = bus5.data_out;
        end else if (sel == 2'd2) begin
            o_busy = bus4.busy;
            o_done = bus4.done;
            o_dup  = bus4.dup;
            o_res  = bus4.res_bank;
            o_dout = bus4.data_out;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write L entries {key, index=address} into bank A; start rides on the
    // last write. Returns just after the edge that accepted start.
    task automatic load(input int L, input int keys[8], input logic desc);
        for (int a = 0; a < L; a++) begin
            tb_wr_en   = 1'b1;
            tb_wr_addr = a[2:0];
            tb_data_in = {keys[a][IW-1:0], a[XW-1:0]};
            if (a == L - 1) begin
                tb_start = 1'b1;
                tb_desc  = desc;
            end
            @(posedge clk); #1;
        end
        tb_wr_en = 1'b0;
        tb_start = 1'b0;
    endtask

    // poke_at > 0 drives a write to address 0 plus start (opposite order)
    // for one cycle while the sort is running; both must be ignored.
    task automatic run_sort(input string name, input int L, input int keys[8],
                            input logic desc, input int poke_at);
        logic [DW-1:0] m [8];
        logic [DW-1:0] cur;
        logic [DW-1:0] got;
        logic          exp_dup;
        int            p;
        int            n;
        int            j;
        for (int i = 0; i < L; i++) begin
            m[i] = {keys[i][IW-1:0], i[XW-1:0]};
        end
        for (int i = 1; i < L; i++) begin
            cur = m[i];
            j = i - 1;
            while (j >= 0 && (desc ? (m[j][DW-1 -: IW] < cur[DW-1 -: IW])
                                   : (m[j][DW-1 -: IW] > cur[DW-1 -: IW]))) begin
                m[j+1] = m[j];
                j--;
            end
            m[j+1] = cur;
        end
        exp_dup = 1'b0;
        for (int i = 0; i < L; i++) begin
            exp_q.push_back(m[i]);
            if (i > 0 && m[i][DW-1 -: IW] == m[i-1][DW-1 -: IW]) begin
                exp_dup = 1'b1;
            end
        end
        p = 0;
        while ((1 << p) < L) p++;

        load(L, keys, desc);
        check_eq({name, " busy_after_start"}, 32'(o_busy), 32'd1);

        n = 0;
        while (o_done !== 1'b1 && n < 2000) begin
            if (poke_at > 0 && n == poke_at) begin
                tb_wr_en   = 1'b1;
                tb_wr_addr = '0;
                tb_data_in = '0;
                tb_start   = 1'b1;
                tb_desc    = ~desc;
            end
            @(posedge clk); #1;
            n++;
            tb_wr_en = 1'b0;
            tb_start = 1'b0;
        end
        check_eq({name, " done_cycles"}, 32'(n), 32'(p * (2 * L + 1) + 1));
        check_eq({name, " busy_at_done"}, 32'(o_busy), 32'd0);
        check_eq({name, " res_bank"}, 32'(o_res), 32'(p % 2));
        check_eq({name, " dup"}, 32'(o_dup), 32'(exp_dup));
        @(posedge clk); #1;
        check_eq({name, " done_pulse"}, 32'(o_done), 32'd0);

        for (int a = 0; a < L; a++) begin
            tb_rd_en   = 1'b1;
            tb_rd_addr = a[2:0];
            @(posedge clk); #1;
            got = o_dout;
            if (exp_q.size() == 0) begin
                check_eq({name, " sb_empty"}, 32'd1, 32'd0);
            end else begin
                check_eq($sformatf("%s entry%0d", name, a), 32'(got), 32'(exp_q.pop_front()));
            end
        end
        tb_rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    int k_asc [8] = '{7, 3, 5, 1, 6, 2, 8, 4};
    int k_dup [8] = '{7, 3, 5, 1, 5, 2, 8, 4};
    int k_five[8] = '{4, 0, 4, 2, 1, 0, 0, 0};
    int k_all9[8] = '{9, 9, 9, 9, 0, 0, 0, 0};

    initial begin
        sel        = 2'd0;
        tb_start   = 1'b0;
        tb_desc    = 1'b0;
        tb_wr_en   = 1'b0;
        tb_rd_en   = 1'b0;
        tb_wr_addr = '0;
        tb_rd_addr = '0;
        tb_data_in = '0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst busy", 32'(o_busy), 32'd0);
        check_eq("rst done", 32'(o_done), 32'd0);
        check_eq("rst dup", 32'(o_dup), 32'd0);
        check_eq("rst res_bank", 32'(o_res), 32'd0);
        check_eq("rst data_out", 32'(o_dout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sort("asc8", 8, k_asc, 1'b0, 0);
        run_sort("desc8_dup", 8, k_dup, 1'b1, 0);
        run_sort("ignore_busy", 8, k_asc, 1'b0, 20);

        // Reset during the final pass of a descending sort with duplicates.
        load(8, k_dup, 1'b1);
        repeat (48) @(posedge clk);
        #1;
        check_eq("mid busy", 32'(o_busy), 32'd1);
        check_eq("mid dup", 32'(o_dup), 32'd1);
        check_eq("mid res_bank_prev", 32'(o_res), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("midrst busy", 32'(o_busy), 32'd0);
        check_eq("midrst done", 32'(o_done), 32'd0);
        check_eq("midrst dup", 32'(o_dup), 32'd0);
        check_eq("midrst res_bank", 32'(o_res), 32'd0);
        check_eq("midrst data_out", 32'(o_dout), 32'd0);
        @(posedge clk); #1;
        run_sort("after_rst", 8, k_dup, 1'b1, 0);

        sel = 2'd1;
        run_sort("len5_asc", 5, k_five, 1'b0, 0);
        run_sort("len5_desc", 5, k_five, 1'b1, 0);

        sel = 2'd2;
        run_sort("len4_stable", 4, k_all9, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/merge_sort_ctrl.md
# merge_sort_ctrl

Parametrised successor of the field-ordering merge sort: a bottom-up, stable merge sort over `LIST_LEN` entries of `{key, index}`, ping-ponging between two internal dual-port RAM banks. It adds three things the previous generation lacks:

- arbitrary (non-power-of-two) list length;
- a run-time ascending/descending mode;
- duplicate-key detection on the final pass.

Duplicate detection is what field ordering needs to decide whether to reject the sample. The block sits between the PRNG/key loader and the permutation/support generation stage.

## Interface
Parameters:
- `INT_WIDTH`, 32: key width (MSBs of each entry).
- `INDEX_WIDTH`, 13: payload/index width (LSBs of each entry).
- `LIST_LEN`, 8192: number of entries; any value ≥ 2.
- `ADDR_W`, `CLOG2(LIST_LEN)`: address width. This is a derived parameter; do not override it.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: single-cycle pulse that begins a sort; honoured only in IDLE.
- `descend`, in, 1: sort order, sampled on an accepted `start`. 0 = ascending, 1 = descending.
- `wr_en`, in, 1: host write into bank A; honoured only when `busy` = 0.
- `wr_addr`, in, ADDR_W: host write address.
- `data_in`, in, INT_WIDTH+INDEX_WIDTH: entry to write, laid out as `{key, index}`.
- `rd_en`, in, 1: host read of the result bank; honoured only when `busy` = 0.
- `rd_addr`, in, ADDR_W: host read address.
- `data_out`, out, INT_WIDTH+INDEX_WIDTH: read data, registered.
- `busy`, out, 1: high from the cycle after an accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse when the sort completes.
- `dup`, out, 1: high if the sorted output contains two equal keys. Valid from `done` until the next accepted `start`.
- `res_bank`, out, 1: bank holding the current result. 0 = A, 1 = B.

## Operation
**States:** IDLE → RUN → FIN → IDLE.

**IDLE**
- `wr_en` writes bank A.
- `rd_en` reads bank `res_bank`.
- An accepted `start` latches `descend`, clears `dup`, sets run width w = 1 and source = A, and enters RUN.
- If `wr_en` and `start` arrive in the same cycle, the write is committed and is visible to the sort.

**RUN (one pass per w)**
- For each base = 0, 2w, 4w, … < LIST_LEN: merge left run [base, min(base+w, L)) with right run [min(base+w, L), min(base+2w, L)) into the destination bank at the same addresses.
- Head pointers are i (left) and j (right); bank port a reads i and port b reads j.
- When both heads are valid:
  - ascending: take the left head if key_l ≤ key_r, otherwise the right head;
  - descending: take the left head if key_l ≥ key_r.
- Ties always take the left head, which makes the sort stable.
- When one run is exhausted, copy the rest of the other run.
- The output pointer k advances by one per element written.
- After the last element of a pass, toggle the source bank and double w (w computed at ADDR_W+1 bits, no overflow).
- When w ≥ LIST_LEN after doubling, enter FIN.

**Pass count and result bank**
- Passes P = CLOG2(LIST_LEN).
- The result lands in B if P is odd, in A if P is even.
- `res_bank` updates at FIN.

**Duplicate detection (final pass only)**
- Compare the key of each written element with the key of the previously written element.
- Any equality sets `dup`, which is sticky until the next `start`.

**FIN**
- Pulse `done`, drop `busy`, return to IDLE.

**Ignored inputs:** `start`, `wr_en` and `rd_en` are ignored while `busy`. `data_out` holds its last value.

**Reset (including mid-sort)**
- State → IDLE; `busy`, `done`, `dup` and `res_bank` → 0; `data_out` → 0.
- RAM contents are not cleared. A partial pass is abandoned.

## Timing
- Host read latency: 1 cycle. `rd_en` at edge t produces `data_out` valid after edge t+1.
- Each element takes 2 cycles:
  - cycle 1: issue reads of heads i and j;
  - cycle 2: compare, write the destination, advance the pointer.
- Each pass takes 2·LIST_LEN cycles, plus 1 turnaround cycle (bank toggle and w update).
- `start` accepted at edge t0 gives `busy` = 1 from t0+1.
- `done` is high for exactly the one cycle after edge t0 + P·(2·LIST_LEN+1) + 1. `busy` falls on the same edge.
- A new `start` is accepted in the cycle after `done`.

## Test plan
- **Basic ascending sort.** LIST_LEN=8, keys {7,3,5,1,6,2,8,4} with index=address, ascending. Expect:
  - result in B (P=3);
  - keys 1..8 with indexes {3,5,1,7,2,4,0,6};
  - `done` after exactly 3·17+1 = 52 cycles;
  - `dup` = 0.
- **Descending with duplicates.** Same data with key 6 replaced by 5, descending. Expect:
  - keys {8,7,5,5,4,3,2,1};
  - the two 5s in index order {2,4};
  - `dup` = 1.
- **Non-power-of-two length.** LIST_LEN=5, keys {4,0,4,2,1}. Expect:
  - P=3, result in B;
  - keys {0,1,2,4,4} with indexes {1,4,3,0,2};
  - `dup` = 1.
- **Even pass count and stability.** LIST_LEN=4, all keys 9. Expect:
  - result in A (P=2);
  - indexes unchanged {0,1,2,3};
  - `done` at 2·9+1 = 19 cycles;
  - `dup` = 1.
- **Inputs ignored while busy.** Assert `wr_en` (addr 0, key 0) and `start` mid-sort. Expect:
  - bank A unchanged;
  - no restart;
  - the original `done` timing holds.
- **Reset mid-operation.** `rst_n` = 0 mid-pass. Expect:
  - next cycle `busy` = `done` = `dup` = `res_bank` = 0;
  - a subsequent sort of the same data gives the correct result.
